// File: rtl/frame_loader.sv
// frame_loader: assembles a sync-prefixed RGB byte stream into a back bank
// and swaps it to the front on the next frame_sync after a complete frame.
module frame_loader #(
    parameter int         FRAME_WIDTH    = 10,
    parameter int         FRAME_HEIGHT   = 20,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    frame_sync,
    output logic [FRAME_HEIGHT-1:0] frame_R [FRAME_WIDTH],
    output logic [FRAME_HEIGHT-1:0] frame_G [FRAME_WIDTH],
    output logic [FRAME_HEIGHT-1:0] frame_B [FRAME_WIDTH],
    output logic                    frame_swapped,
    output logic                    load_error,
    output logic [15:0]             frames_loaded
);

    localparam int BYTES_PER_COL = (FRAME_HEIGHT + 7) / 8;
    localparam int PAD_W         = BYTES_PER_COL * 8;
    localparam int COL_W         = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int BYTE_W        = (BYTES_PER_COL > 1) ? $clog2(BYTES_PER_COL) : 1;
    localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                front_sel_r;
    logic                back_sel_s;
    logic [COL_W-1:0]    col_cnt_r;
    logic [1:0]          color_cnt_r;
    logic [BYTE_W-1:0]   byte_cnt_r;
    logic [TO_W-1:0]     timeout_r;
    logic                in_ready_r;
    logic                frame_swapped_r;
    logic                load_error_r;
    logic [15:0]         frames_loaded_r;

    logic                accept_s;
    logic                write_en_s;
    logic                start_s;
    logic                swap_s;
    logic                abort_s;
    logic                last_byte_s;
    logic                timeout_hit_s;
    logic [PAD_W-1:0]    pad_data_s;
    logic [PAD_W-1:0]    pad_mask_s;
    logic [FRAME_HEIGHT-1:0] wr_data_s;
    logic [FRAME_HEIGHT-1:0] wr_mask_s;

    // bank_r[bank][color][column]; color 0=R, 1=G, 2=B
    logic [FRAME_HEIGHT-1:0] bank_r [2][3][FRAME_WIDTH];

    assign back_sel_s = ~front_sel_r;

    // Position flags: last byte of the frame and timeout expiry
    always_comb begin
        last_byte_s   = (col_cnt_r == COL_W'(FRAME_WIDTH - 1)) &&
                        (color_cnt_r == 2'd2) &&
                        (byte_cnt_r == BYTE_W'(BYTES_PER_COL - 1));
        timeout_hit_s = (timeout_r == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Place the incoming byte at its 8-bit lane; lanes beyond the height drop
    always_comb begin
        pad_data_s = PAD_W'(in_data) << {byte_cnt_r, 3'b000};
        pad_mask_s = PAD_W'(8'hFF) << {byte_cnt_r, 3'b000};
        wr_data_s  = pad_data_s[FRAME_HEIGHT-1:0];
        wr_mask_s  = pad_mask_s[FRAME_HEIGHT-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        write_en_s  = 1'b0;
        start_s     = 1'b0;
        swap_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    if (in_data == SYNC_BYTE) begin
                        start_s     = 1'b1;
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    write_en_s = 1'b1;
                    if (last_byte_s) begin
                        state_nxt_s = ST_PENDING;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else if (timeout_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_PENDING: begin
                if (frame_sync) begin
                    swap_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Column / color / byte position counters within the frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_cnt_r   <= '0;
            color_cnt_r <= 2'd0;
            byte_cnt_r  <= '0;
        end else if (start_s) begin
            col_cnt_r   <= '0;
            color_cnt_r <= 2'd0;
            byte_cnt_r  <= '0;
        end else if (write_en_s) begin
            if (byte_cnt_r == BYTE_W'(BYTES_PER_COL - 1)) begin
                byte_cnt_r <= '0;
                if (color_cnt_r == 2'd2) begin
                    color_cnt_r <= 2'd0;
                    col_cnt_r   <= col_cnt_r + COL_W'(1);
                end else begin
                    color_cnt_r <= color_cnt_r + 2'd1;
                end
            end else begin
                byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
            end
        end else begin
            col_cnt_r   <= col_cnt_r;
            color_cnt_r <= color_cnt_r;
            byte_cnt_r  <= byte_cnt_r;
        end
    end

    // Idle-gap counter: only runs while waiting for a byte inside LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= '0;
        end else if ((state_r == ST_LOAD) && !accept_s && !abort_s) begin
            timeout_r <= timeout_r + TO_W'(1);
        end else begin
            timeout_r <= '0;
        end
    end

    // Back-bank write of the accepted data byte (read-modify-write of one lane)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 3; c++) begin
                    for (int x = 0; x < FRAME_WIDTH; x++) begin
                        bank_r[b][c][x] <= '0;
                    end
                end
            end
        end else if (write_en_s) begin
            bank_r[back_sel_s][color_cnt_r][col_cnt_r] <=
                (bank_r[back_sel_s][color_cnt_r][col_cnt_r] & ~wr_mask_s) |
                (wr_data_s & wr_mask_s);
        end else begin
            bank_r <= bank_r;
        end
    end

    // Front-bank select, status pulses, ready and frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            front_sel_r     <= 1'b0;
            frame_swapped_r <= 1'b0;
            load_error_r    <= 1'b0;
            frames_loaded_r <= 16'd0;
            in_ready_r      <= 1'b0;
        end else begin
            frame_swapped_r <= swap_s;
            load_error_r    <= abort_s;
            in_ready_r      <= (state_nxt_s != ST_PENDING);
            if (swap_s) begin
                front_sel_r     <= ~front_sel_r;
                frames_loaded_r <= frames_loaded_r + 16'd1;
            end else begin
                front_sel_r     <= front_sel_r;
                frames_loaded_r <= frames_loaded_r;
            end
        end
    end

    // Front bank is always presented straight from storage
    always_comb begin
        for (int x = 0; x < FRAME_WIDTH; x++) begin
            frame_R[x] = bank_r[front_sel_r][0][x];
            frame_G[x] = bank_r[front_sel_r][1][x];
            frame_B[x] = bank_r[front_sel_r][2][x];
        end
    end

    assign in_ready      = in_ready_r;
    assign frame_swapped = frame_swapped_r;
    assign load_error    = load_error_r;
    assign frames_loaded = frames_loaded_r;

endmodule

// File: tb/tb_frame_loader.sv
// Directed self-checking bench for frame_loader (10x20 frame, short timeout).
module tb_frame_loader;

    localparam int W   = 10;
    localparam int H   = 20;
    localparam int NB  = 90;
    localparam int TMO = 16;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         frame_sync;
    logic [H-1:0] frame_R [W];
    logic [H-1:0] frame_G [W];
    logic [H-1:0] frame_B [W];
    logic         frame_swapped;
    logic         load_error;
    logic [15:0]  frames_loaded;

    int passes = 0;
    int total  = 0;
    logic [7:0] frame_q [NB];

    frame_loader #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frame_sync   (frame_sync),
        .frame_R      (frame_R),
        .frame_G      (frame_G),
        .frame_B      (frame_B),
        .frame_swapped(frame_swapped),
        .load_error   (load_error),
        .frames_loaded(frames_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_frame(input bit sync_on_last);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk); #1;
        for (int i = 0; i < NB; i++) begin
            in_data = frame_q[i];
            if (sync_on_last && i == NB - 1) frame_sync = 1'b1;
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic pulse_sync(input logic expect_swap);
        frame_sync = 1'b1;
        @(posedge clk); #1;
        frame_sync = 1'b0;
        check("swap_pulse", 32'(frame_swapped), 32'(expect_swap));
        @(posedge clk); #1;
        check("swap_clear", 32'(frame_swapped), 32'd0);
    endtask

    function automatic logic [19:0] pattern_word(input int x, input int c);
        int i0;
        logic [7:0] b0, b1, b2;
        i0 = x * 9 + c * 3;
        b0 = (i0 == 0) ? 8'hA5 : 8'(i0);
        b1 = 8'(i0 + 1);
        b2 = 8'(i0 + 2);
        return {b2[3:0], b1, b0};
    endfunction

    initial begin
        int first_k;
        int pulses;
        reset      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        frame_sync = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(frames_loaded), 32'd0);
        check("rst_R0", 32'(frame_R[0]), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_release", 32'(in_ready), 32'd1);

        // all-0xFF frame: upper 4 bits of byte 2 dropped
        for (int i = 0; i < NB; i++) frame_q[i] = 8'hFF;
        send_frame(1'b0);
        check("ready_pending", 32'(in_ready), 32'd0);
        check("no_early_swap", 32'(frame_swapped), 32'd0);
        pulse_sync(1'b1);
        check("count1", 32'(frames_loaded), 32'd1);
        for (int x = 0; x < W; x++) begin
            check("ff_R", 32'(frame_R[x]), 32'h000F_FFFF);
            check("ff_G", 32'(frame_G[x]), 32'h000F_FFFF);
            check("ff_B", 32'(frame_B[x]), 32'h000F_FFFF);
        end
        check("ready_idle", 32'(in_ready), 32'd1);

        // column 3 red only
        for (int i = 0; i < NB; i++) frame_q[i] = 8'h00;
        frame_q[27] = 8'h12;
        frame_q[28] = 8'h34;
        frame_q[29] = 8'h5F;
        send_frame(1'b0);
        pulse_sync(1'b1);
        check("col3_R3", 32'(frame_R[3]), 32'h000F_3412);
        check("col3_R2", 32'(frame_R[2]), 32'd0);
        check("col3_R4", 32'(frame_R[4]), 32'd0);
        check("col3_G3", 32'(frame_G[3]), 32'd0);
        check("col3_B9", 32'(frame_B[9]), 32'd0);
        check("count2", 32'(frames_loaded), 32'd2);

        // leading junk discarded, 0xA5 at data position 0 kept as data
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk); #1;
        in_data  = 8'h7E;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) frame_q[i] = (i == 0) ? 8'hA5 : 8'(i);
        send_frame(1'b0);
        check("pat_ready_pending", 32'(in_ready), 32'd0);
        pulse_sync(1'b1);
        check("pat_R0", 32'(frame_R[0]), 32'h0002_01A5);
        check("pat_G0", 32'(frame_G[0]), 32'h0005_0403);
        check("pat_B9", 32'(frame_B[9]), 32'h0009_5857);
        for (int x = 0; x < W; x++) begin
            check("pat_R", 32'(frame_R[x]), 32'(pattern_word(x, 0)));
            check("pat_G", 32'(frame_G[x]), 32'(pattern_word(x, 1)));
            check("pat_B", 32'(frame_B[x]), 32'(pattern_word(x, 2)));
        end
        check("count3", 32'(frames_loaded), 32'd3);

        // timeout abort after 40 data bytes
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk); #1;
        in_data  = 8'h33;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        first_k  = 0;
        pulses   = 0;
        for (int k = 1; k <= 2 * TMO; k++) begin
            @(posedge clk); #1;
            if (load_error) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        check("tmo_pulses", 32'(pulses), 32'd1);
        check("tmo_latency", 32'(first_k), 32'(TMO));
        check("tmo_ready", 32'(in_ready), 32'd1);
        pulse_sync(1'b0);
        check("tmo_front_kept", 32'(frame_R[0]), 32'h0002_01A5);
        check("tmo_count", 32'(frames_loaded), 32'd3);

        // frame_sync on the last-byte edge is ignored
        for (int i = 0; i < NB; i++) frame_q[i] = 8'h81;
        send_frame(1'b1);
        check("late_no_swap", 32'(frame_swapped), 32'd0);
        check("late_pending", 32'(in_ready), 32'd0);
        check("late_front", 32'(frame_R[0]), 32'h0002_01A5);
        @(posedge clk); #1;
        check("late_still_pending", 32'(in_ready), 32'd0);
        pulse_sync(1'b1);
        check("late_R5", 32'(frame_R[5]), 32'h0001_8181);
        check("late_B0", 32'(frame_B[0]), 32'h0001_8181);
        check("count4", 32'(frames_loaded), 32'd4);

        // second frame swaps back to the other bank
        for (int i = 0; i < NB; i++) frame_q[i] = 8'h00;
        send_frame(1'b0);
        pulse_sync(1'b1);
        check("back_R0", 32'(frame_R[0]), 32'd0);
        check("back_G9", 32'(frame_G[9]), 32'd0);
        check("count5", 32'(frames_loaded), 32'd5);

        // asynchronous reset in the middle of LOAD
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk); #1;
        in_data  = 8'h5A;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rl_ready", 32'(in_ready), 32'd0);
        check("rl_count", 32'(frames_loaded), 32'd0);
        check("rl_swapped", 32'(frame_swapped), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rl_ready_back", 32'(in_ready), 32'd1);
        check("rl_R0", 32'(frame_R[0]), 32'd0);

        // asynchronous reset while PENDING
        for (int i = 0; i < NB; i++) frame_q[i] = 8'hFF;
        send_frame(1'b0);
        check("rp_pending", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("rp_ready", 32'(in_ready), 32'd0);
        check("rp_count", 32'(frames_loaded), 32'd0);
        check("rp_R0", 32'(frame_R[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rp_ready_back", 32'(in_ready), 32'd1);
        pulse_sync(1'b0);
        check("rp_no_swap_count", 32'(frames_loaded), 32'd0);
        check("rp_B3", 32'(frame_B[3]), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
# frame_loader

Writer side of the game frame buffer. Accepts a byte stream (from the MCU SPI receiver) carrying a full RGB frame and assembles it into a back buffer. On a frame boundary it swaps the back buffer to the front buffer, so the blitter always reads a complete, tear-free frame. It sits between the SPI byte receiver and the screen blitter's `frame_R/G/B` inputs.

## Interface
- `FRAME_WIDTH`, default 10: columns per frame.
- `FRAME_HEIGHT`, default 20: bits (rows) per column.
- `SYNC_BYTE`, default 8'hA5: start-of-frame marker.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles between bytes inside a frame.
- Derived: `BYTES_PER_COL` = ceil(`FRAME_HEIGHT`/8). `FRAME_BYTES` = `FRAME_WIDTH`·3·`BYTES_PER_COL`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte.
- `frame_sync`  in  1  one-cycle pulse at start of vertical blank.
- `frame_R`, `frame_G`, `frame_B`  out  [FRAME_HEIGHT-1:0] × [FRAME_WIDTH-1:0]  front buffer, unpacked by column.
- `frame_swapped`  out  1  one-cycle pulse when the front buffer changes.
- `load_error`  out  1  one-cycle pulse on timeout abort.
- `frames_loaded`  out  16  count of swapped frames; wraps 0xFFFF→0.

## Operation
- A byte is accepted on a rising `clk` edge with `in_valid && in_ready`. A byte is never accepted while `in_ready`=0, and the producer holds it.
- Storage:
  - Two banks of R/G/B arrays plus a registered `front_sel`.
  - Outputs always show the bank selected by `front_sel`.
  - Writes go only to the other bank.
- State IDLE (`in_ready`=1):
  - A byte equal to `SYNC_BYTE` → LOAD; column, color and byte counters are cleared.
  - Any other byte is discarded silently.
- State LOAD (`in_ready`=1):
  - Byte order per column x (0..`FRAME_WIDTH`-1): R bytes 0..`BYTES_PER_COL`-1, then G, then B.
  - Byte k of color c in column x writes back[c][x] bits [8k+7:8k]. Bits at index ≥ `FRAME_HEIGHT` are dropped.
  - `SYNC_BYTE` values inside LOAD are treated as data.
  - Acceptance of byte `FRAME_BYTES`-1 → PENDING.
  - Timeout counter:
    - Clears on each accepted byte and on LOAD entry.
    - Increments otherwise.
    - When it reaches `TIMEOUT_CYCLES`-1, the frame aborts: → IDLE, `load_error` pulses.
    - The back bank keeps its partial contents and is never swapped.
- State PENDING (`in_ready`=0):
  - On `frame_sync`=1: toggle `front_sel`, pulse `frame_swapped`, increment `frames_loaded`, → IDLE.
- The new back bank (the old front) is not cleared. The next frame overwrites every stored bit.

## Timing
- Reset asserted: state IDLE, `front_sel`=0, both banks all-zero. Outputs: `frame_R/G/B` all 0, `in_ready`=0 while reset is low, `frame_swapped`=0, `load_error`=0, `frames_loaded`=0.
- `in_ready` is registered and is a function of the state only. It goes 1 on the first edge after reset release.
- `frame_swapped` and the new front data appear on the edge that samples `frame_sync`=1 in PENDING. Latency from the last accepted byte to swap is at least 1 cycle.
- If `frame_sync` is high on the same edge that accepts the last byte, it is ignored. The swap waits for the next `frame_sync`.
- `frame_sync` in IDLE or LOAD has no effect.
- If the timeout expires on the same edge a byte is accepted, the byte wins and the counter clears.
- Reset mid-LOAD or mid-PENDING returns everything to reset values immediately (asynchronous).
- Throughput: one byte per cycle in LOAD.

## Test plan
Defaults apply (10×20, 3 bytes/col, 90 data bytes).

- Reset, then stream 0xA5 + 90 bytes with value 0xFF, then pulse `frame_sync` → `in_ready`=0 after byte 90. On the sync edge, `frame_swapped`=1 for 1 cycle, `frames_loaded`=1, and every `frame_R/G/B[x]`=20'hFFFFF (bits 20..23 dropped).
- Column 3 R bytes 0x12, 0x34, 0x5F, all other bytes 0x00, then sync → `frame_R[3]`=20'hF3412. All other columns and colors are 0.
- Bytes 0x00, 0x7E, then 0xA5 + frame → leading bytes are discarded and the frame loads correctly. A 0xA5 at data position 0 is stored as data.
- 0xA5 + 40 bytes, then `in_valid`=0 for `TIMEOUT_CYCLES` cycles → `load_error` pulses once and the state returns to IDLE. A following `frame_sync` gives no swap and no change to front data.
- `frame_sync` held high on the edge accepting the last byte → no swap. The next `frame_sync` pulse swaps. A second full frame swaps back to bank 0 and `frames_loaded`=2.
- Assert `reset` low mid-LOAD and during PENDING → all outputs are zero, `frames_loaded`=0, and `in_ready` returns high after release.
